// File: rtl/mc_main_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// States, opcodes, ALU/mux encodings and the grouped control-output struct.
package mc_main_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_RTEX   = 4'd6,
        ST_RTWB   = 4'd7,
        ST_BRANCH = 4'd8,
        ST_IMMEX  = 4'd9,
        ST_IMMWB  = 4'd10,
        ST_JUMP   = 4'd11
    } mc_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       extop;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_supported = 1'b1;
            default:                        op_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state decode for the main controller.
// Unsupported opcodes fall straight back to FETCH from DECODE.
module mc_next_state
    import mc_main_ctrl_pkg::*;
(
    input  mc_state_t   state_i,
    input  logic [5:0]  op_i,
    output mc_state_t   state_o
);

    always_comb begin
        state_o = ST_FETCH;
        case (state_i)
            ST_FETCH:  state_o = ST_DECODE;
            ST_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW:             state_o = ST_MEMADR;
                    OP_RTYPE:                 state_o = ST_RTEX;
                    OP_BEQ, OP_BNE:           state_o = ST_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_o = ST_IMMEX;
                    OP_J:                     state_o = ST_JUMP;
                    default:                  state_o = ST_FETCH;
                endcase
            end
            // Only lw and sw reach MEMADR, so anything but sw is a load.
            ST_MEMADR: state_o = (op_i == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  state_o = ST_MEMWB;
            ST_RTEX:   state_o = ST_RTWB;
            ST_IMMEX:  state_o = ST_IMMWB;
            ST_MEMWB, ST_MEMWR, ST_RTWB, ST_IMMWB,
            ST_BRANCH, ST_JUMP: state_o = ST_FETCH;
            default:   state_o = ST_FETCH;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle MIPS core: state register, Moore output
// decode (pcen also looks at op/zero in BRANCH) and retired-instruction counter.
module mc_main_ctrl
    import mc_main_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             zero,
    output logic             iord,
    output logic             irwrite,
    output logic             memwrite,
    output logic             pcen,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       aluop,
    output logic             extop,
    output logic             regwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       dbg_state
);

    mc_state_t        state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    ctrl_t            ctrl;
    logic             retire;

    mc_next_state u_next_state (
        .state_i (state_q),
        .op_i    (op),
        .state_o (state_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                ctrl.pcen    = 1'b1;
            end
            // Branch target is computed here while the opcode is decoded.
            ST_DECODE: begin
                ctrl.alusrcb = SRCB_IMM_SH2;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.extop   = 1'b1;
                ctrl.illegal = ~op_supported(op);
            end
            ST_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.extop   = 1'b1;
            end
            ST_MEMRD: ctrl.iord = 1'b1;
            ST_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            ST_RTEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REGB;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            ST_RTWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REGB;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.pcen    = ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
            end
            ST_IMMEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                case (op)
                    OP_ANDI: ctrl.aluop = ALUOP_AND;
                    OP_ORI:  ctrl.aluop = ALUOP_OR;
                    default: begin
                        ctrl.aluop = ALUOP_ADD;
                        ctrl.extop = 1'b1;
                    end
                endcase
            end
            ST_IMMWB: ctrl.regwrite = 1'b1;
            ST_JUMP: begin
                ctrl.pcsrc = PCSRC_JUMP;
                ctrl.pcen  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    always_comb begin
        case (state_q)
            ST_MEMWB, ST_MEMWR, ST_RTWB, ST_IMMWB,
            ST_BRANCH, ST_JUMP: retire = 1'b1;
            ST_DECODE:          retire = ctrl.illegal;
            default:            retire = 1'b0;
        endcase
        instret_d = retire ? instret_q + {{(CNT_W-1){1'b0}}, 1'b1} : instret_q;
    end

    assign iord      = ctrl.iord;
    assign irwrite   = ctrl.irwrite;
    assign memwrite  = ctrl.memwrite;
    assign pcen      = ctrl.pcen;
    assign pcsrc     = ctrl.pcsrc;
    assign alusrca   = ctrl.alusrca;
    assign alusrcb   = ctrl.alusrcb;
    assign aluop     = ctrl.aluop;
    assign extop     = ctrl.extop;
    assign regwrite  = ctrl.regwrite;
    assign regdst    = ctrl.regdst;
    assign memtoreg  = ctrl.memtoreg;
    assign illegal   = ctrl.illegal;
    assign instret   = instret_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: per-cycle expected control vectors are
// queued per instruction and compared cycle by cycle; a CNT_W=4 copy checks wrap.
module tb_mc_main_ctrl;
    import mc_main_ctrl_pkg::*;

    localparam int W = 21;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = 6'b100011;
    logic        zero = 1'b0;

    logic        iord, irwrite, memwrite, pcen, alusrca, extop;
    logic        regwrite, regdst, memtoreg, illegal;
    logic [1:0]  pcsrc, alusrcb;
    logic [2:0]  aluop;
    logic [31:0] instret;
    logic [3:0]  dbg_state;

    logic        iord_4, irwrite_4, memwrite_4, pcen_4, alusrca_4, extop_4;
    logic        regwrite_4, regdst_4, memtoreg_4, illegal_4;
    logic [1:0]  pcsrc_4, alusrcb_4;
    logic [2:0]  aluop_4;
    logic [3:0]  instret_4;
    logic [3:0]  dbg_state_4;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    logic [31:0]  exp_ret;
    int           n_checks = 0;
    int           n_fail = 0;

    wire [W-1:0] obs = {dbg_state, iord, irwrite, memwrite, pcen, pcsrc, alusrca,
                        alusrcb, aluop, extop, regwrite, regdst, memtoreg, illegal};

    always #5 clk = ~clk;

    mc_main_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .pcen(pcen),
        .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .extop(extop), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .illegal(illegal), .instret(instret), .dbg_state(dbg_state)
    );

    mc_main_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .iord(iord_4), .irwrite(irwrite_4), .memwrite(memwrite_4), .pcen(pcen_4),
        .pcsrc(pcsrc_4), .alusrca(alusrca_4), .alusrcb(alusrcb_4), .aluop(aluop_4),
        .extop(extop_4), .regwrite(regwrite_4), .regdst(regdst_4), .memtoreg(memtoreg_4),
        .illegal(illegal_4), .instret(instret_4), .dbg_state(dbg_state_4)
    );

    function automatic logic legal_op(input logic [5:0] o);
        return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 || o == 6'b000100 ||
               o == 6'b000101 || o == 6'b001000 || o == 6'b001100 || o == 6'b001101 ||
               o == 6'b000010;
    endfunction

    // Expected outputs for one cycle in state st, straight from the control table.
    function automatic logic [W-1:0] cyc_vec(input mc_state_t st, input logic [5:0] o,
                                             input logic z);
        logic io, irw, mw, pe, sa, ex, rw, rd, mtr, ill;
        logic [1:0] ps, sb;
        logic [2:0] ao;
        {io, irw, mw, pe, sa, ex, rw, rd, mtr, ill} = '0;
        ps = 2'b00; sb = 2'b00; ao = 3'b000;
        case (st)
            ST_FETCH:  begin irw = 1; sb = 2'b01; pe = 1; end
            ST_DECODE: begin sb = 2'b11; ex = 1; ill = !legal_op(o); end
            ST_MEMADR: begin sa = 1; sb = 2'b10; ex = 1; end
            ST_MEMRD:  io = 1;
            ST_MEMWB:  begin rw = 1; mtr = 1; end
            ST_MEMWR:  begin io = 1; mw = 1; end
            ST_RTEX:   begin sa = 1; ao = 3'b010; end
            ST_RTWB:   begin rw = 1; rd = 1; end
            ST_BRANCH: begin
                sa = 1; ao = 3'b001; ps = 2'b01;
                pe = (o == 6'b000100 && z) || (o == 6'b000101 && !z);
            end
            ST_IMMEX: begin
                sa = 1; sb = 2'b10;
                if (o == 6'b001100) ao = 3'b011;
                else if (o == 6'b001101) ao = 3'b100;
                else ex = 1;
            end
            ST_IMMWB:  rw = 1;
            ST_JUMP:   begin ps = 2'b10; pe = 1; end
            default:   ;
        endcase
        return {st, io, irw, mw, pe, ps, sa, sb, ao, ex, rw, rd, mtr, ill};
    endfunction

    // Driver: set inputs for one instruction and queue its per-cycle expectations.
    task automatic push_instr(input logic [5:0] o, input logic z);
        op = o;
        zero = z;
        exp_q.push_back(cyc_vec(ST_FETCH, o, z));
        exp_q.push_back(cyc_vec(ST_DECODE, o, z));
        case (o)
            6'b100011: begin
                exp_q.push_back(cyc_vec(ST_MEMADR, o, z));
                exp_q.push_back(cyc_vec(ST_MEMRD, o, z));
                exp_q.push_back(cyc_vec(ST_MEMWB, o, z));
            end
            6'b101011: begin
                exp_q.push_back(cyc_vec(ST_MEMADR, o, z));
                exp_q.push_back(cyc_vec(ST_MEMWR, o, z));
            end
            6'b000000: begin
                exp_q.push_back(cyc_vec(ST_RTEX, o, z));
                exp_q.push_back(cyc_vec(ST_RTWB, o, z));
            end
            6'b000100, 6'b000101: exp_q.push_back(cyc_vec(ST_BRANCH, o, z));
            6'b001000, 6'b001100, 6'b001101: begin
                exp_q.push_back(cyc_vec(ST_IMMEX, o, z));
                exp_q.push_back(cyc_vec(ST_IMMWB, o, z));
            end
            6'b000010: exp_q.push_back(cyc_vec(ST_JUMP, o, z));
            default: ;
        endcase
        exp_ret = exp_ret + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op = 6'b100011;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dbg_state !== 4'(ST_FETCH)) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_FETCH);
        end
        n_checks++;
        if (instret !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_instret: got %0d expected 0", instret);
        end
        exp_ret = 0;
        reset = 1'b0;
    endtask

    task automatic test_lw();
        push_instr(6'b100011, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL lw_cycle: got %h expected %h", obs, e);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (instret !== exp_ret) begin
            n_fail++;
            $display("FAIL lw_instret: got %0d expected %0d", instret, exp_ret);
        end
    endtask

    task automatic test_sw();
        int cycles;
        cycles = 0;
        push_instr(6'b101011, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL sw_cycle: got %h expected %h", obs, e);
            end
            @(posedge clk); #1;
            cycles++;
        end
        n_checks++;
        if (dbg_state !== 4'(ST_FETCH) || cycles != 4) begin
            n_fail++;
            $display("FAIL sw_return: state %0d after %0d cycles, expected FETCH after 4",
                     dbg_state, cycles);
        end
    endtask

    task automatic test_branch();
        logic [6:0] cases [4];
        cases[0] = {6'b000100, 1'b1};
        cases[1] = {6'b000100, 1'b0};
        cases[2] = {6'b000101, 1'b0};
        cases[3] = {6'b000101, 1'b1};
        for (int i = 0; i < 4; i++) begin
            push_instr(cases[i][6:1], cases[i][0]);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL branch%0d_cycle: got %h expected %h", i, obs, e);
                end
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (instret !== exp_ret) begin
            n_fail++;
            $display("FAIL branch_instret: got %0d expected %0d", instret, exp_ret);
        end
    endtask

    task automatic test_alu_jump();
        logic [5:0] ops [5];
        ops[0] = 6'b001101;
        ops[1] = 6'b000010;
        ops[2] = 6'b001000;
        ops[3] = 6'b001100;
        ops[4] = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            push_instr(ops[i], 1'($urandom_range(0, 1)));
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL alu_jump%0d_cycle: got %h expected %h", i, obs, e);
                end
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (instret !== exp_ret) begin
            n_fail++;
            $display("FAIL alu_jump_instret: got %0d expected %0d", instret, exp_ret);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [3];
        ops[0] = 6'b111111;
        ops[1] = 6'b000001;
        ops[2] = 6'b100000;
        for (int i = 0; i < 3; i++) begin
            push_instr(ops[i], 1'b0);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL illegal%0d_cycle: got %h expected %h", i, obs, e);
                end
                @(posedge clk); #1;
            end
            n_checks++;
            if (instret !== exp_ret) begin
                n_fail++;
                $display("FAIL illegal%0d_instret: got %0d expected %0d", i, instret, exp_ret);
            end
        end
    endtask

    task automatic test_reset_mid();
        op = 6'b101011;
        zero = 1'b0;
        exp_q.push_back(cyc_vec(ST_FETCH, op, zero));
        exp_q.push_back(cyc_vec(ST_DECODE, op, zero));
        exp_q.push_back(cyc_vec(ST_MEMADR, op, zero));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid_cycle: got %h expected %h", obs, e);
            end
            if (exp_q.size() == 0) reset = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (dbg_state !== 4'(ST_FETCH) || memwrite !== 1'b0 || instret !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: state %0d memwrite %b instret %0d, expected 0 0 0",
                     dbg_state, memwrite, instret);
        end
        exp_ret = 0;
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            push_instr(6'b111111, 1'b0);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL wrap_cycle: got %h expected %h", obs, e);
                end
                @(posedge clk); #1;
            end
            if (i == 14) begin
                n_checks++;
                if (instret_4 !== 4'd15) begin
                    n_fail++;
                    $display("FAIL wrap_at_max: got %0d expected 15", instret_4);
                end
            end
        end
        n_checks++;
        if (instret_4 !== exp_ret[3:0] || instret_4 !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_to_zero: got %0d expected 0", instret_4);
        end
        n_checks++;
        if (instret !== exp_ret) begin
            n_fail++;
            $display("FAIL wrap_wide_instret: got %0d expected %0d", instret, exp_ret);
        end
    endtask

    initial begin
        exp_ret = 0;
        test_reset();
        test_lw();
        test_sw();
        test_branch();
        test_alu_jump();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
